// File: rtl/mp_alu_if.sv
// Streaming bus of the byte-serial ALU: command, operand-in and result-out channels.
// The master side is the controller; the slave side is the ALU.
interface mp_alu_if #(
    parameter int PREC_W = 2
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [PREC_W-1:0] cfg_prec;
    logic [2:0]        cfg_op;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;

    modport master (
        output cfg_valid, cfg_prec, cfg_op, in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cfg_valid, cfg_prec, cfg_op, in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mp_alu_stream.sv
// Byte-serial multi-precision ALU: loads A then B LSB-first, computes once,
// then streams the result LSB-first. One operation in flight at a time.
module mp_alu_stream #(
    parameter int MAX_BYTES = 4,
    parameter int PREC_W    = 2
) (
    input  logic       clk,
    input  logic       rst,
    mp_alu_if.slave    bus,
    output logic [3:0] flags,
    output logic       busy
);
    localparam int W_MAX    = 8 * MAX_BYTES;
    localparam int LOG2_MAX = $clog2(MAX_BYTES);
    localparam int CNT_W    = (LOG2_MAX == 0) ? 1 : LOG2_MAX;
    localparam int SH_W     = $clog2(W_MAX);
    localparam logic [PREC_W-1:0] PREC_MAX = PREC_W'(LOG2_MAX);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, DRAIN} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SRA} op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PREC_W-1:0] prec_q, prec_d;
    logic [W_MAX-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
    logic [3:0]        flags_q, flags_d;

    logic [CNT_W:0]   nbytes;
    logic [W_MAX-1:0] mask, sign_mask, a_ext, sra_tmp, alu_r;
    logic [W_MAX:0]   carry_mask, sum, diff;
    logic [SH_W:0]    wbits;
    logic [SH_W-1:0]  shamt;
    logic             a_msb, b_msb, r_msb, alu_c, alu_v, last_byte;

    // Everything is computed at full width; the active width W=8N is selected by masks
    // that mark the live bytes, the sign bit W-1 and the carry bit W.
    always_comb begin
        nbytes = (CNT_W+1)'(1) << prec_q;
        mask   = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            mask[8*i +: 8] = (i < int'(nbytes)) ? 8'hFF : 8'h00;
        end
        sign_mask  = mask ^ (mask >> 1);
        carry_mask = {mask, 1'b1} ^ {1'b0, mask};
        wbits      = (SH_W+1)'(8) << prec_q;
        shamt      = b_q[SH_W-1:0] & SH_W'(wbits - 1'b1);
        sum        = {1'b0, a_q} + {1'b0, b_q};
        diff       = {1'b0, a_q} - {1'b0, b_q};
        a_msb      = |(a_q & sign_mask);
        b_msb      = |(b_q & sign_mask);
        a_ext      = a_msb ? (a_q | ~mask) : a_q;
        sra_tmp    = $signed(a_ext) >>> shamt;
        alu_r      = '0;
        alu_c      = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_r = sum[W_MAX-1:0] & mask;
                alu_c = |(sum & carry_mask);
            end
            OP_SUB: begin
                alu_r = diff[W_MAX-1:0] & mask;
                alu_c = (a_q < b_q);
            end
            OP_AND:  alu_r = a_q & b_q;
            OP_OR:   alu_r = a_q | b_q;
            OP_XOR:  alu_r = a_q ^ b_q;
            OP_SHL:  alu_r = (a_q << shamt) & mask;
            OP_SHR:  alu_r = a_q >> shamt;
            default: alu_r = sra_tmp & mask;
        endcase
        r_msb = |(alu_r & sign_mask);
        alu_v = 1'b0;
        if (op_q == OP_ADD) begin
            alu_v = (a_msb == b_msb) && (r_msb != a_msb);
        end else if (op_q == OP_SUB) begin
            alu_v = (a_msb != b_msb) && (r_msb != a_msb);
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        prec_d        = prec_q;
        a_d           = a_q;
        b_d           = b_q;
        r_d           = r_q;
        flags_d       = flags_q;
        bus.cfg_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        bus.out_last  = 1'b0;
        last_byte     = ({1'b0, cnt_q} == (nbytes - 1'b1));
        case (state_q)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid) begin
                    prec_d  = (bus.cfg_prec > PREC_MAX) ? PREC_MAX : bus.cfg_prec;
                    op_d    = op_t'(bus.cfg_op);
                    a_d     = '0;
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            LOAD_A, LOAD_B: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (state_q == LOAD_A) a_d[8*cnt_q +: 8] = bus.in_data;
                    else                   b_d[8*cnt_q +: 8] = bus.in_data;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : EXEC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EXEC: begin
                r_d     = alu_r;
                flags_d = {alu_v, r_msb, (alu_r == '0), alu_c};
                state_d = DRAIN;
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = r_q[8*cnt_q +: 8];
                bus.out_last  = last_byte;
                if (bus.out_ready) begin
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            prec_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            prec_q  <= prec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mp_alu_stream.sv
// Directed and random operations on mp_alu_stream; expected result bytes are queued
// from a reference model when an operation is issued and popped as the DUT drains.
module tb_mp_alu_stream;
    localparam int MAX_BYTES = 4;
    localparam int PREC_W    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] flags;
    logic       busy;

    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] exp_q[$];
    logic [3:0] exp_flags;

    always #5 clk = ~clk;

    mp_alu_if #(.PREC_W(PREC_W)) bus ();

    mp_alu_stream #(.MAX_BYTES(MAX_BYTES), .PREC_W(PREC_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .flags(flags),
        .busy (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model written directly from the operation definitions at width W=8N.
    function automatic void model(input int prec, input int op, input logic [31:0] a_in,
                                  input logic [31:0] b_in, output logic [31:0] r,
                                  output logic [3:0] f);
        int nb, w, sh;
        longint unsigned m, a, b, s, res;
        bit c, v, as, bs;
        nb  = 1 << ((prec > 2) ? 2 : prec);
        w   = 8 * nb;
        m   = (64'd1 << w) - 1;
        a   = longint'(a_in) & m;
        b   = longint'(b_in) & m;
        sh  = int'(b % longint'(w));
        as  = a[w-1];
        bs  = b[w-1];
        c   = 1'b0;
        v   = 1'b0;
        res = 0;
        case (op)
            0: begin s = a + b; res = s & m; c = s[w]; v = (as == bs) && (res[w-1] != as); end
            1: begin res = (a - b) & m; c = (a < b); v = (as != bs) && (res[w-1] != as); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (a << sh) & m;
            6: res = a >> sh;
            default: begin
                res = a >> sh;
                if (as) res = res | (m & ~(m >> sh));
            end
        endcase
        r = res[31:0];
        f = {v, res[w-1], (res == 0), c};
    endfunction

    task automatic sendByte(input logic [7:0] d);
        int t;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) checkValue("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic sendCmd(input int prec, input int op);
        int t;
        t = 0;
        while (!bus.cfg_ready && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) checkValue("cfg_ready_timeout", {31'd0, bus.cfg_ready}, 32'd1);
        bus.cfg_valid = 1'b1;
        bus.cfg_prec  = PREC_W'(prec);
        bus.cfg_op    = 3'(op);
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int prec, input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [3:0]  f;
        int          nb;
        nb = 1 << ((prec > 2) ? 2 : prec);
        sendCmd(prec, op);
        model(prec, op, a, b, r, f);
        for (int k = 0; k < nb; k++) exp_q.push_back({(k == nb - 1), r[8*k +: 8]});
        exp_flags = f;
        for (int k = 0; k < nb; k++) sendByte(a[8*k +: 8]);
        for (int k = 0; k < nb; k++) sendByte(b[8*k +: 8]);
        checkValue("exec_no_out_valid", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic checkOutput(input int stall_idx, input int stall_cycles);
        logic [8:0] e;
        int         idx, t;
        tick();
        checkValue("first_byte_latency", {31'd0, bus.out_valid}, 32'd1);
        idx = 0;
        while (exp_q.size() > 0) begin
            t = 0;
            while (!bus.out_valid && t < 20) begin
                tick();
                t++;
            end
            if (t == 20) begin
                checkValue("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
                exp_q.delete();
                return;
            end
            e = exp_q.pop_front();
            checkValue("out_data", {24'd0, bus.out_data}, {24'd0, e[7:0]});
            checkValue("out_last", {31'd0, bus.out_last}, {31'd0, e[8]});
            if (idx == stall_idx) begin
                bus.out_ready = 1'b0;
                repeat (stall_cycles) begin
                    tick();
                    checkValue("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                    checkValue("stall_data", {24'd0, bus.out_data}, {24'd0, e[7:0]});
                    checkValue("stall_last", {31'd0, bus.out_last}, {31'd0, e[8]});
                end
                bus.out_ready = 1'b1;
            end
            tick();
            idx++;
        end
        checkValue("no_extra_byte", {31'd0, bus.out_valid}, 32'd0);
        checkValue("idle_after_drain", {31'd0, busy}, 32'd0);
        checkValue("flags", {28'd0, flags}, {28'd0, exp_flags});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_prec  = '0;
        bus.cfg_op    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        checkValue("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
        checkValue("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkValue("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkValue("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        checkValue("rst_busy", {31'd0, busy}, 32'd0);
        checkValue("rst_flags", {28'd0, flags}, 32'd0);
        rst = 1'b0;
        tick();

        // operand bytes offered while idle must not be taken
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (2) tick();
        checkValue("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkValue("idle_busy", {31'd0, busy}, 32'd0);
        bus.in_valid = 1'b0;

        applyStimulus(0, 0, 32'h0000_00FF, 32'h0000_0001);
        checkOutput(-1, 0);
        applyStimulus(1, 1, 32'h0000_0001, 32'h0000_0002);
        checkOutput(-1, 0);
        applyStimulus(2, 0, 32'h7FFF_FFFF, 32'h0000_0001);
        checkOutput(-1, 0);
        applyStimulus(2, 7, 32'h8000_0000, 32'h0000_001F);
        checkOutput(-1, 0);
        applyStimulus(2, 6, 32'h8000_0000, 32'h0000_001F);
        checkOutput(-1, 0);
        applyStimulus(1, 4, 32'h0000_1234, 32'h0000_00FF);
        checkOutput(0, 5);
        applyStimulus(3, 5, 32'h0000_0081, 32'h0000_0021);
        checkOutput(1, 2);

        // reset in the middle of loading A discards the operation
        sendCmd(2, 2);
        for (int k = 0; k < 3; k++) sendByte(8'h11 * (k + 1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkValue("midrst_busy", {31'd0, busy}, 32'd0);
        checkValue("midrst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
        checkValue("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkValue("midrst_flags", {28'd0, flags}, 32'd0);
        applyStimulus(0, 2, 32'h0000_00F0, 32'h0000_003C);
        checkOutput(-1, 0);

        for (int n = 0; n < 16; n++) begin
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom, $urandom);
            checkOutput(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
